// File: rtl/pipe_mux_sel_pkg.sv
// Shared defaults and helpers for the registered channel-select block.
package pipe_mux_sel_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_NUM_IN = 3;

  // Ceiling log2, floored at 1 so a select bus always has at least one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N-way channel selector; out-of-range selects fall back to the
// last channel and are flagged so the caller can track them.
module mux_n_comb
  import pipe_mux_sel_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned NUM_IN = DEF_NUM_IN,
  parameter int unsigned SEL_W  = clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    oor_o
);

  localparam logic [SEL_W:0]   LIMIT = NUM_IN[SEL_W:0];
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM_IN - 1);

  logic [WIDTH-1:0] ch [NUM_IN];
  logic [SEL_W-1:0] eff_sel;

  // Unpack the flat bus and pick the channel, clamping to the last input.
  always_comb begin
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      ch[k] = data_i[k*WIDTH +: WIDTH];
    end
    oor_o   = ({1'b0, sel_i} >= LIMIT);
    eff_sel = oor_o ? LAST : sel_i;
    data_o  = ch[eff_sel];
  end

endmodule

// File: rtl/pipe_mux_sel.sv
// Registered channel select: one pipeline stage after mux_n_comb, with
// stall/flush control and a sticky out-of-range select flag.
module pipe_mux_sel
  import pipe_mux_sel_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned NUM_IN = DEF_NUM_IN,
  parameter int unsigned SEL_W  = clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    err_clr,
  output logic [WIDTH-1:0]        data_out,
  output logic                    out_valid,
  output logic                    sel_err
);

  logic [WIDTH-1:0] mux_data;
  logic             mux_oor;
  logic [WIDTH-1:0] data_d,  data_q;
  logic             valid_d, valid_q;
  logic             err_d,   err_q;
  logic             accept;

  mux_n_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .data_i (data_in),
    .sel_i  (sel),
    .data_o (mux_data),
    .oor_o  (mux_oor)
  );

  // Next-state: flush only kills valid; stall holds everything; set beats clear.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    accept  = !flush && !stall;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      data_d  = mux_data;
      valid_d = in_valid;
    end
    if (accept && in_valid && mux_oor) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Output stage flops with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign sel_err   = err_q;

endmodule

// File: doc/pipe_mux_sel.md
PIPE_MUX_SEL -- requirements
Module: pipe_mux_sel

Interface
REQ-001 Parameter WIDTH, default 32: data width of every input channel and of data_out.
REQ-002 Parameter NUM_IN, default 3: number of input channels, legal range 2..16.
REQ-003 Parameter SEL_W, default clog2(NUM_IN): select width, minimum 1.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 data_in  input  NUM_IN*WIDTH  flat channel bus; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 sel  input  SEL_W  channel select, sampled together with in_valid.
REQ-008 in_valid  input  1  the current data_in/sel pair is a real transfer.
REQ-009 stall  input  1  downstream not ready; output stage holds its value.
REQ-010 flush  input  1  discard the output stage contents.
REQ-011 err_clr  input  1  clear the sticky error flag.
REQ-012 data_out  output  WIDTH  registered selected data.
REQ-013 out_valid  output  1  data_out holds a valid transfer.
REQ-014 sel_err  output  1  sticky flag: an out-of-range sel was accepted.

Function
REQ-015 Latency SHALL be exactly one clock: a transfer accepted at edge N appears on data_out/out_valid after edge N.
REQ-016 The output stage SHALL accept a transfer when stall=0 and flush=0: it loads data_out with channel sel and loads out_valid with in_valid.
REQ-017 When stall=1 and flush=0, data_out and out_valid SHALL hold their values and no transfer SHALL be accepted.
REQ-018 When flush=1, out_valid SHALL clear on the next edge regardless of stall or in_valid; data_out SHALL hold its value.
REQ-019 When sel >= NUM_IN, the output stage SHALL select channel NUM_IN-1. This preserves the legacy default-to-last-input behaviour.
REQ-020 sel_err SHALL set on any edge that accepts a transfer with in_valid=1 and sel >= NUM_IN.
REQ-021 An out-of-range sel with in_valid=0, during a stall, or during a flush SHALL NOT set sel_err.
REQ-022 sel_err SHALL remain set until err_clr=1; on that edge sel_err SHALL clear.
REQ-023 If err_clr=1 and a set condition occur on the same edge, set SHALL win and sel_err SHALL remain 1.
REQ-024 When NUM_IN is a power of two, no sel value is out of range and sel_err SHALL never assert.
REQ-025 The path from data_in to data_out SHALL be combinational-free at the output: data_out SHALL be driven directly from a flop.

Reset
REQ-026 While rst_n=0: data_out=0, out_valid=0, sel_err=0, asynchronously and independent of clk.
REQ-027 A reset asserted mid-stall SHALL discard held data; the first edge after release SHALL behave as a normal accept.

Structure
REQ-028 A shared package SHALL hold the default WIDTH (32), the default NUM_IN (3), and a clog2 helper function.
REQ-029 The combinational channel selector SHALL be a sub-module, mux_n_comb (WIDTH, NUM_IN, SEL_W), containing the REQ-019 rule.
REQ-030 pipe_mux_sel SHALL contain only the output register, the valid bit, and the sticky error logic.
REQ-031 The block SHALL be a drop-in for the three-way writeback select when instantiated with WIDTH=32 and NUM_IN=3, with one added pipeline stage.

Verification
REQ-032 Bench SHALL cover the following with NUM_IN=3, WIDTH=32, and channels A=0x1111_1111, B=0x2222_2222, C=0x3333_3333:
- sel=1, in_valid=1, stall=0 at edge 1 -> after edge 1, data_out=0x2222_2222 and out_valid=1; not visible before edge 1.
- Load sel=0, then stall=1 for 3 edges while sel=2 -> data_out stays 0x1111_1111 and out_valid stays 1; after stall drops, the next edge gives 0x3333_3333.
- sel=3, in_valid=1 -> data_out=0x3333_3333 and sel_err=1. sel_err remains 1 across 5 further edges and clears only on the err_clr=1 edge.
- sel=3 with err_clr=1 on the same edge -> sel_err=1. sel=3 with in_valid=0 -> sel_err stays 0.
- flush=1 and stall=1 together while out_valid=1 -> out_valid=0 after the edge and data_out unchanged.
- rst_n driven low between clock edges while out_valid=1 and sel_err=1 -> all outputs are 0 immediately. With NUM_IN=4, sweep sel 0..3 -> no sel_err.
